// File: rtl/sram_uart_tx_interface.sv
// Reads a block of 16-bit words from SRAM and sends each word as two 8N1 UART
// frames, high byte first, prefetching the next word while the low byte is sent.
module sram_uart_tx_interface #(
  parameter int CLOCKS_PER_BIT = 434,
  parameter int READ_LATENCY   = 2
) (
  input  logic        Clock,
  input  logic        Resetn,
  input  logic        Start,
  input  logic [17:0] Start_address,
  input  logic [17:0] Word_count,
  output logic [17:0] SRAM_address,
  output logic        SRAM_we_n,
  input  logic [15:0] SRAM_read_data,
  output logic        UART_TX_O,
  output logic        Busy,
  output logic        Done
);

  localparam int BW = (CLOCKS_PER_BIT > 1) ? $clog2(CLOCKS_PER_BIT) : 1;
  localparam int LW = $clog2(READ_LATENCY + 1);
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLOCKS_PER_BIT - 1);
  localparam logic [LW-1:0] LAT_LOAD  = LW'(READ_LATENCY);
  localparam logic [LW-1:0] LAT_LAST  = LW'(1);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_START_BIT, S_DATA_BITS, S_STOP_BIT
  } state_t;

  state_t      state, state_next;
  logic [BW-1:0] baud_cnt;
  logic [LW-1:0] lat_cnt;
  logic [LW-1:0] pf_cnt;
  logic [2:0]  bit_idx;
  logic [17:0] remaining;   // words still to send after the one in flight
  logic [7:0]  shift_reg;
  logic [7:0]  low_byte;
  logic [15:0] hold_word;
  logic        high_byte;
  logic        zero_pend;

  logic accept, baud_done, more_words;

  assign SRAM_we_n  = 1'b1;
  assign accept     = Start && !Busy;
  assign baud_done  = (baud_cnt == BAUD_LAST);
  assign more_words = (remaining != '0);

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) state <= S_IDLE;
    else         state <= state_next;
  end

  // NOTE: default first so every path assigns state_next and no latch is inferred.
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:      if (accept && Word_count != '0) state_next = S_FETCH;
      S_FETCH:     if (lat_cnt == LAT_LAST) state_next = S_START_BIT;
      S_START_BIT: if (baud_done) state_next = S_DATA_BITS;
      S_DATA_BITS: if (baud_done && bit_idx == 3'd7) state_next = S_STOP_BIT;
      S_STOP_BIT:  if (baud_done) state_next = (high_byte || more_words) ? S_START_BIT : S_IDLE;
      default:     state_next = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values; later assignments in this block take priority.
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      UART_TX_O    <= 1'b1;
      Busy         <= 1'b0;
      Done         <= 1'b0;
      SRAM_address <= '0;
      zero_pend    <= 1'b0;
      remaining    <= '0;
      baud_cnt     <= '0;
      bit_idx      <= '0;
      lat_cnt      <= '0;
      pf_cnt       <= '0;
      high_byte    <= 1'b0;
      shift_reg    <= '0;
      low_byte     <= '0;
      hold_word    <= '0;
    end else begin
      Done <= 1'b0;
      if (zero_pend) begin
        Done      <= 1'b1;
        Busy      <= 1'b0;
        zero_pend <= 1'b0;
      end
      // Prefetch of the next word runs in parallel with the low-byte frame.
      if (pf_cnt != '0) begin
        pf_cnt <= pf_cnt - 1'b1;
        if (pf_cnt == LAT_LAST) hold_word <= SRAM_read_data;
      end
      case (state)
        S_IDLE: begin
          if (accept) begin
            Busy      <= 1'b1;
            remaining <= Word_count - 18'd1;
            if (Word_count == '0) begin
              zero_pend <= 1'b1;
            end else begin
              SRAM_address <= Start_address;
              lat_cnt      <= LAT_LOAD;
            end
          end
        end
        S_FETCH: begin
          if (lat_cnt == LAT_LAST) begin
            shift_reg <= SRAM_read_data[15:8];
            low_byte  <= SRAM_read_data[7:0];
            high_byte <= 1'b1;
            UART_TX_O <= 1'b0;
            baud_cnt  <= '0;
          end
          lat_cnt <= lat_cnt - 1'b1;
        end
        S_START_BIT: begin
          baud_cnt <= baud_done ? '0 : baud_cnt + 1'b1;
          if (baud_done) begin
            UART_TX_O <= shift_reg[0];
            shift_reg <= shift_reg >> 1;
            bit_idx   <= '0;
          end
        end
        S_DATA_BITS: begin
          baud_cnt <= baud_done ? '0 : baud_cnt + 1'b1;
          if (baud_done) begin
            if (bit_idx == 3'd7) begin
              UART_TX_O <= 1'b1;
            end else begin
              UART_TX_O <= shift_reg[0];
              shift_reg <= shift_reg >> 1;
              bit_idx   <= bit_idx + 1'b1;
            end
          end
        end
        S_STOP_BIT: begin
          baud_cnt <= baud_done ? '0 : baud_cnt + 1'b1;
          if (baud_done) begin
            if (high_byte) begin
              UART_TX_O <= 1'b0;
              shift_reg <= low_byte;
              high_byte <= 1'b0;
              if (more_words) begin
                SRAM_address <= SRAM_address + 18'd1;
                pf_cnt       <= LAT_LOAD;
              end
            end else if (more_words) begin
              UART_TX_O <= 1'b0;
              shift_reg <= hold_word[15:8];
              low_byte  <= hold_word[7:0];
              high_byte <= 1'b1;
              remaining <= remaining - 18'd1;
            end else begin
              Done <= 1'b1;
              Busy <= 1'b0;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sram_uart_tx_interface.sv
// Directed bench for sram_uart_tx_interface with a one-stage SRAM read model
// (CLOCKS_PER_BIT=4, READ_LATENCY=2); line activity is recorded per cycle.
module tb_sram_uart_tx_interface;

  localparam int CPB   = 4;
  localparam int RL    = 2;
  localparam int FRAME = 10 * CPB;

  logic        Clock = 1'b0;
  logic        Resetn;
  logic        Start;
  logic [17:0] Start_address;
  logic [17:0] Word_count;
  logic [17:0] SRAM_address;
  logic        SRAM_we_n;
  logic [15:0] SRAM_read_data;
  logic        UART_TX_O;
  logic        Busy;
  logic        Done;

  int errors = 0;
  int checks = 0;

  logic [15:0] mem [0:262143];
  logic        wave   [0:255];
  logic        done_w [0:255];
  logic        busy_w [0:255];
  logic [17:0] addr_w [0:255];

  sram_uart_tx_interface #(.CLOCKS_PER_BIT(CPB), .READ_LATENCY(RL)) dut (
    .Clock(Clock), .Resetn(Resetn), .Start(Start), .Start_address(Start_address),
    .Word_count(Word_count), .SRAM_address(SRAM_address), .SRAM_we_n(SRAM_we_n),
    .SRAM_read_data(SRAM_read_data), .UART_TX_O(UART_TX_O), .Busy(Busy), .Done(Done)
  );

  always #10 Clock = ~Clock;

  // Data registered one edge after the address edge, sampled by the DUT on the next.
  always @(posedge Clock) SRAM_read_data <= mem[SRAM_address];

  // Called on a negedge; returns on the negedge after the accept edge (index 0).
  task issue_start(input logic [17:0] addr, input logic [17:0] cnt);
    Start = 1'b1; Start_address = addr; Word_count = cnt;
    @(negedge Clock);
    Start = 1'b0; Start_address = 18'h15555; Word_count = 18'h00007;
  endtask

  task collect(input int n);
    for (int i = 0; i < n; i++) begin
      wave[i] = UART_TX_O; done_w[i] = Done; busy_w[i] = Busy; addr_w[i] = SRAM_address;
      @(negedge Clock);
    end
  endtask

  function automatic int frame_errs(input int base, input logic [7:0] b);
    int n = 0;
    for (int j = 0; j < FRAME; j++) begin
      int bi = j / CPB;
      logic e;
      e = (bi == 0) ? 1'b0 : (bi == 9) ? 1'b1 : b[bi-1];
      if (wave[base + j] !== e) n++;
    end
    return n;
  endfunction

  function automatic int done_count(input int n);
    int c = 0;
    for (int i = 0; i < n; i++) if (done_w[i] === 1'b1) c++;
    return c;
  endfunction

  task test_reset;
    Resetn = 1'b0; Start = 1'b0; Start_address = '0; Word_count = '0;
    repeat (2) @(negedge Clock);
    checks++; if (UART_TX_O !== 1'b1) begin errors++; $display("FAIL reset_tx: got %b want 1", UART_TX_O); end
    checks++; if (Busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", Busy); end
    checks++; if (Done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", Done); end
    checks++; if (SRAM_address !== 18'h0) begin errors++; $display("FAIL reset_addr: got %h want 0", SRAM_address); end
    checks++; if (SRAM_we_n !== 1'b1) begin errors++; $display("FAIL reset_we_n: got %b want 1", SRAM_we_n); end
    Resetn = 1'b1;
    @(negedge Clock);
  endtask

  task test_single_word;
    int n;
    mem[18'h00100] = 16'h41A5;
    issue_start(18'h00100, 18'd1);
    collect(84);
    checks++; if (busy_w[0] !== 1'b1) begin errors++; $display("FAIL single_busy_accept: got %b want 1", busy_w[0]); end
    checks++; if (wave[1] !== 1'b1) begin errors++; $display("FAIL single_line_edge1: got %b want 1", wave[1]); end
    checks++; if (wave[2] !== 1'b0) begin errors++; $display("FAIL single_line_edge2: got %b want 0", wave[2]); end
    n = frame_errs(2, 8'h41);
    checks++; if (n !== 0) begin errors++; $display("FAIL single_frame_hi: %0d bad cycles, want 0", n); end
    n = frame_errs(2 + FRAME, 8'hA5);
    checks++; if (n !== 0) begin errors++; $display("FAIL single_frame_lo: %0d bad cycles, want 0", n); end
    checks++; if (done_w[82] !== 1'b1 || done_w[81] !== 1'b0) begin errors++; $display("FAIL single_done_time: got %b%b want 01", done_w[81], done_w[82]); end
    checks++; if (busy_w[82] !== 1'b0 || busy_w[81] !== 1'b1) begin errors++; $display("FAIL single_busy_drop: got %b%b want 10", busy_w[81], busy_w[82]); end
    n = done_count(84);
    checks++; if (n !== 1) begin errors++; $display("FAIL single_done_pulses: got %0d want 1", n); end
    checks++; if (wave[83] !== 1'b1) begin errors++; $display("FAIL single_idle_line: got %b want 1", wave[83]); end
    checks++; if (addr_w[83] !== 18'h00100) begin errors++; $display("FAIL single_addr_hold: got %h want 00100", addr_w[83]); end
  endtask

  task test_zero_count;
    int lows = 0, moves = 0;
    issue_start(18'h2AAAA, 18'd0);
    collect(4);
    for (int i = 0; i < 4; i++) begin
      if (wave[i] !== 1'b1) lows++;
      if (addr_w[i] !== 18'h00100) moves++;
    end
    checks++; if (busy_w[0] !== 1'b1 || done_w[0] !== 1'b0) begin errors++; $display("FAIL zero_accept: busy=%b done=%b want 1 0", busy_w[0], done_w[0]); end
    checks++; if (done_w[1] !== 1'b1 || busy_w[1] !== 1'b0) begin errors++; $display("FAIL zero_done: done=%b busy=%b want 1 0", done_w[1], busy_w[1]); end
    checks++; if (done_w[2] !== 1'b0) begin errors++; $display("FAIL zero_done_width: got %b want 0", done_w[2]); end
    checks++; if (lows !== 0) begin errors++; $display("FAIL zero_line: %0d low cycles want 0", lows); end
    checks++; if (moves !== 0) begin errors++; $display("FAIL zero_addr: %0d changed cycles want 0", moves); end
  endtask

  task test_back_to_back;
    logic [7:0] bytes [0:5];
    int n;
    bytes = '{8'h12, 8'h34, 8'hBE, 8'hEF, 8'h00, 8'hFF};
    mem[18'h00200] = 16'h1234; mem[18'h00201] = 16'hBEEF; mem[18'h00202] = 16'h00FF;
    issue_start(18'h00200, 18'd3);
    collect(244);
    for (int f = 0; f < 6; f++) begin
      n = frame_errs(2 + f * FRAME, bytes[f]);
      checks++; if (n !== 0) begin errors++; $display("FAIL b2b_frame%0d: %0d bad cycles, want 0", f, n); end
    end
    checks++; if (addr_w[41] !== 18'h00200 || addr_w[42] !== 18'h00201) begin errors++; $display("FAIL b2b_addr1: got %h %h want 00200 00201", addr_w[41], addr_w[42]); end
    checks++; if (addr_w[121] !== 18'h00201 || addr_w[122] !== 18'h00202) begin errors++; $display("FAIL b2b_addr2: got %h %h want 00201 00202", addr_w[121], addr_w[122]); end
    checks++; if (addr_w[243] !== 18'h00202) begin errors++; $display("FAIL b2b_addr_end: got %h want 00202", addr_w[243]); end
    checks++; if (done_w[242] !== 1'b1 || done_w[241] !== 1'b0 || busy_w[242] !== 1'b0) begin errors++; $display("FAIL b2b_done: d241=%b d242=%b b242=%b want 0 1 0", done_w[241], done_w[242], busy_w[242]); end
  endtask

  task test_ignore_start;
    int n;
    mem[18'h00300] = 16'hC30F; mem[18'h00301] = 16'h5A81;
    issue_start(18'h00300, 18'd2);
    fork
      collect(164);
      begin
        repeat (9) @(negedge Clock);
        Start = 1'b1; Start_address = 18'h00200; Word_count = 18'd5;
        @(negedge Clock); Start = 1'b0;
        repeat (40) @(negedge Clock);
        Start = 1'b1; Start_address = 18'h00100; Word_count = 18'd1;
        @(negedge Clock); Start = 1'b0;
        repeat (110) @(negedge Clock);
        Start = 1'b1; Start_address = 18'h00202; Word_count = 18'd0;
        @(negedge Clock); Start = 1'b0;
      end
    join
    n = frame_errs(2, 8'hC3) + frame_errs(2 + FRAME, 8'h0F)
      + frame_errs(2 + 2 * FRAME, 8'h5A) + frame_errs(2 + 3 * FRAME, 8'h81);
    checks++; if (n !== 0) begin errors++; $display("FAIL ignore_frames: %0d bad cycles, want 0", n); end
    checks++; if (addr_w[42] !== 18'h00301 || addr_w[163] !== 18'h00301) begin errors++; $display("FAIL ignore_addr: got %h %h want 00301 00301", addr_w[42], addr_w[163]); end
    n = done_count(164);
    checks++; if (done_w[162] !== 1'b1 || n !== 1) begin errors++; $display("FAIL ignore_done: d162=%b pulses=%0d want 1 1", done_w[162], n); end
    checks++; if (busy_w[163] !== 1'b0) begin errors++; $display("FAIL ignore_relatch: busy=%b want 0", busy_w[163]); end
  endtask

  task test_wrap;
    int n;
    mem[18'h3FFFF] = 16'h8001; mem[18'h00000] = 16'h7E3C;
    issue_start(18'h3FFFF, 18'd2);
    collect(164);
    checks++; if (addr_w[41] !== 18'h3FFFF || addr_w[42] !== 18'h00000) begin errors++; $display("FAIL wrap_addr: got %h %h want 3ffff 00000", addr_w[41], addr_w[42]); end
    n = frame_errs(2, 8'h80) + frame_errs(2 + FRAME, 8'h01)
      + frame_errs(2 + 2 * FRAME, 8'h7E) + frame_errs(2 + 3 * FRAME, 8'h3C);
    checks++; if (n !== 0) begin errors++; $display("FAIL wrap_frames: %0d bad cycles, want 0", n); end
    checks++; if (done_w[162] !== 1'b1) begin errors++; $display("FAIL wrap_done: got %b want 1", done_w[162]); end
  endtask

  task test_reset_mid;
    int n;
    mem[18'h00150] = 16'h96C3;
    issue_start(18'h00150, 18'd1);
    repeat (7) @(negedge Clock);
    checks++; if (UART_TX_O !== 1'b0) begin errors++; $display("FAIL rstmid_pre_line: got %b want 0", UART_TX_O); end
    #3 Resetn = 1'b0;
    #1;
    checks++; if (UART_TX_O !== 1'b1 || Busy !== 1'b0) begin errors++; $display("FAIL rstmid_async: tx=%b busy=%b want 1 0", UART_TX_O, Busy); end
    checks++; if (SRAM_address !== 18'h0 || Done !== 1'b0) begin errors++; $display("FAIL rstmid_regs: addr=%h done=%b want 0 0", SRAM_address, Done); end
    @(negedge Clock);
    Resetn = 1'b1;
    repeat (2) @(negedge Clock);
    issue_start(18'h00150, 18'd1);
    collect(84);
    n = frame_errs(2, 8'h96) + frame_errs(2 + FRAME, 8'hC3);
    checks++; if (n !== 0) begin errors++; $display("FAIL rstmid_frames: %0d bad cycles, want 0", n); end
    checks++; if (done_w[82] !== 1'b1 || busy_w[82] !== 1'b0) begin errors++; $display("FAIL rstmid_done: done=%b busy=%b want 1 0", done_w[82], busy_w[82]); end
  endtask

  initial begin
    test_reset;
    test_single_word;
    test_zero_count;
    test_back_to_back;
    test_ignore_start;
    test_wrap;
    test_reset_mid;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
